// File: rtl/lsu_ecc_scrub_ctl_pkg.sv
// Shared types for the DCCM ECC scrub path: widths, queue entry, ECC encode.
// Imported by the scrub interface, queue and controller.
package lsu_ecc_scrub_ctl_pkg;

  localparam int DCCM_BITS  = 16;
  localparam int DATA_WIDTH = 32;
  localparam int ECC_WIDTH  = 7;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 7;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef logic [DCCM_BITS-1:2] waddr_t;

  typedef struct packed {
    logic                  valid;
    waddr_t                addr;
    logic [DATA_WIDTH-1:0] data;
  } scrub_entry_t;

  function automatic logic [ECC_WIDTH-1:0] rvecc_encode(
    input logic [DATA_WIDTH-1:0] din
  );
    logic [ECC_WIDTH-1:0] e;
    e[0] = ^(din & 32'h56AA_AD5B);
    e[1] = ^(din & 32'h9B33_366D);
    e[2] = ^(din & 32'hE3C3_C78E);
    e[3] = ^(din & 32'h03FC_07F0);
    e[4] = ^(din & 32'h03FF_F800);
    e[5] = ^(din & 32'hFC00_0000);
    // overall parity makes the code SECDED
    e[6] = ^{din, e[5:0]};
    return e;
  endfunction

endpackage

// File: rtl/lsu_ecc_scrub_ctl_if.sv
// Shared DCCM write port bundle: stbuf request/grant and scrub write.
// master = scrub controller, slave = store buffer / DCCM side.
interface lsu_ecc_scrub_ctl_if;
  import lsu_ecc_scrub_ctl_pkg::*;

  logic                  stbuf_reqvld_any;
  logic [DCCM_BITS-1:0]  stbuf_addr_any;
  logic                  stbuf_grant_any;
  logic                  scrub_wren;
  logic [DCCM_BITS-1:0]  scrub_wr_addr;
  logic [DATA_WIDTH-1:0] scrub_wr_data;
  logic [ECC_WIDTH-1:0]  scrub_wr_ecc;

  modport master (
    input  stbuf_reqvld_any, stbuf_addr_any,
    output stbuf_grant_any, scrub_wren,
    output scrub_wr_addr, scrub_wr_data, scrub_wr_ecc
  );

  modport slave (
    output stbuf_reqvld_any, stbuf_addr_any,
    input  stbuf_grant_any, scrub_wren,
    input  scrub_wr_addr, scrub_wr_data, scrub_wr_ecc
  );

endinterface

// File: rtl/lsu_ecc_scrub_fifo.sv
// Scrub queue: circular FIFO with count, up to two writes per cycle and
// word-address invalidate. Ports: flush, wr0/wr1, deq, inv, head, count.
module lsu_ecc_scrub_fifo
  import lsu_ecc_scrub_ctl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_l,
  input  logic             i_flush,
  input  logic             i_wr0_vld,
  input  scrub_entry_t     i_wr0,
  input  logic             i_wr1_vld,
  input  scrub_entry_t     i_wr1,
  input  logic             i_deq,
  input  logic             i_inv_vld,
  input  waddr_t           i_inv_addr,
  output scrub_entry_t     o_head,
  output logic [CNT_W-1:0] o_count
);

  scrub_entry_t     r_q [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_ptr1;

  assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
  assign o_head    = r_q[r_rd_ptr];
  assign o_count   = r_count;

  // later writes win: invalidate, then dequeue, then enqueue,
  // so a full queue can dequeue and refill the same slot
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_q[i].valid <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_inv_vld) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_q[i].valid && r_q[i].addr == i_inv_addr)
            r_q[i].valid <= 1'b0;
        end
      end
      if (i_deq) begin
        r_q[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (i_wr0_vld) r_q[r_wr_ptr] <= i_wr0;
      if (i_wr1_vld) r_q[w_wr_ptr1] <= i_wr1;
      r_wr_ptr <= r_wr_ptr + PTR_W'(i_wr0_vld)
                           + PTR_W'(i_wr1_vld);
      r_count  <= r_count - CNT_W'(i_deq)
                          + CNT_W'(i_wr0_vld)
                          + CNT_W'(i_wr1_vld);
    end
  end

endmodule

// File: rtl/lsu_ecc_scrub_ctl.sv
// Stages dc3 ECC corrections, queues them at dc4 commit and arbitrates
// the DCCM write port (bus) against stbuf drain; overflow/pending flags.
module lsu_ecc_scrub_ctl
  import lsu_ecc_scrub_ctl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  dec_tlu_core_ecc_disable,
  input  logic                  single_ecc_error_hi_dc3,
  input  logic                  single_ecc_error_lo_dc3,
  input  logic                  lsu_double_ecc_error_dc3,
  input  logic [DCCM_BITS-1:0]  lsu_addr_dc3,
  input  logic [DCCM_BITS-1:0]  end_addr_dc3,
  input  logic [DATA_WIDTH-1:0] sec_data_hi_dc3,
  input  logic [DATA_WIDTH-1:0] sec_data_lo_dc3,
  input  logic                  lsu_commit_dc4,
  lsu_ecc_scrub_ctl_if.master   bus,
  output logic                  scrub_overflow,
  output logic                  scrub_pending
);

  localparam logic [CNT_W-1:0] C_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_FULLM1 = CNT_W'(DEPTH - 1);
  localparam logic [STV_W-1:0] C_SMAX   = STV_W'(STARVE_MAX);

  logic             w_dis;
  waddr_t           w_sb_wa;
  scrub_entry_t     w_cap_lo, w_cap_hi;
  scrub_entry_t     r_stg_lo, r_stg_hi;
  scrub_entry_t     w_head, w_wr0;
  logic [CNT_W-1:0] w_count;
  logic [STV_W-1:0] r_starve_cnt;
  logic w_pending, w_full, w_head_ok, w_sel;
  logic w_grant, w_skip, w_deq;
  logic w_lo_req, w_hi_req, w_free1, w_free2;
  logic w_enq_lo, w_enq_hi;
  logic w_unused;

  assign w_dis   = dec_tlu_core_ecc_disable;
  assign w_sb_wa = bus.stbuf_addr_any[DCCM_BITS-1:2];
  assign w_unused = ^{lsu_addr_dc3[1:0], end_addr_dc3[1:0],
                      bus.stbuf_addr_any[1:0]};

  assign w_cap_lo = '{
    valid: single_ecc_error_lo_dc3 & ~lsu_double_ecc_error_dc3 & ~w_dis,
    addr:  lsu_addr_dc3[DCCM_BITS-1:2],
    data:  sec_data_lo_dc3};
  assign w_cap_hi = '{
    valid: single_ecc_error_hi_dc3 & ~lsu_double_ecc_error_dc3 & ~w_dis,
    addr:  end_addr_dc3[DCCM_BITS-1:2],
    data:  sec_data_hi_dc3};

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_stg_lo <= '0;
      r_stg_hi <= '0;
    end else begin
      r_stg_lo <= w_cap_lo;
      r_stg_hi <= w_cap_hi;
    end
  end

  assign w_pending = (w_count != '0);
  assign w_full    = (w_count == C_FULL);
  assign w_head_ok = w_pending & w_head.valid;
  // an invalidated head never wins the port; it is skipped instead
  assign w_sel   = ~w_dis & w_head_ok &
                   (~bus.stbuf_reqvld_any | w_full |
                    (r_starve_cnt == C_SMAX));
  assign w_grant = bus.stbuf_reqvld_any & ~w_sel;
  assign w_skip  = ~w_dis & w_pending & ~w_head.valid;
  assign w_deq   = w_sel | w_skip;

  // a granted stbuf word supersedes a correction to the same word
  assign w_lo_req = r_stg_lo.valid & lsu_commit_dc4 & ~w_dis &
                    ~(w_grant & (r_stg_lo.addr == w_sb_wa));
  assign w_hi_req = r_stg_hi.valid & lsu_commit_dc4 & ~w_dis &
                    ~(w_grant & (r_stg_hi.addr == w_sb_wa));

  // slots free after this cycle's dequeue
  assign w_free1 = (w_count != C_FULL) | w_deq;
  assign w_free2 = (w_count < C_FULLM1) |
                   ((w_count == C_FULLM1) & w_deq);

  assign w_enq_lo = w_lo_req & w_free1;
  assign w_enq_hi = w_hi_req & (w_enq_lo ? w_free2 : w_free1);
  assign w_wr0    = w_enq_lo ? r_stg_lo : r_stg_hi;

  assign scrub_overflow = (w_lo_req & ~w_enq_lo) |
                          (w_hi_req & ~w_enq_hi);

  lsu_ecc_scrub_fifo u_fifo (
    .clk        (clk),
    .rst_l      (rst_l),
    .i_flush    (w_dis),
    .i_wr0_vld  (w_enq_lo | w_enq_hi),
    .i_wr0      (w_wr0),
    .i_wr1_vld  (w_enq_lo & w_enq_hi),
    .i_wr1      (r_stg_hi),
    .i_deq      (w_deq),
    .i_inv_vld  (w_grant),
    .i_inv_addr (w_sb_wa),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_starve_cnt <= '0;
    end else if (w_dis || !w_pending || w_sel) begin
      r_starve_cnt <= '0;
    end else if (w_grant && r_starve_cnt != C_SMAX) begin
      r_starve_cnt <= r_starve_cnt + STV_W'(1);
    end
  end

  assign bus.stbuf_grant_any = w_grant;
  assign bus.scrub_wren      = w_sel;
  assign bus.scrub_wr_addr   = {w_head.addr, 2'b00};
  assign bus.scrub_wr_data   = w_head.data;
  assign bus.scrub_wr_ecc    = rvecc_encode(w_head.data);
  assign scrub_pending       = w_pending;

endmodule

// File: tb/tb_lsu_ecc_scrub_ctl.sv
// Directed bench for lsu_ecc_scrub_ctl: capture latency, commit gating,
// overflow, starvation, coherence invalidate, ecc disable and reset.
module tb_lsu_ecc_scrub_ctl;
  import lsu_ecc_scrub_ctl_pkg::*;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic dis, err_hi, err_lo, dbl, commit;
  logic [DCCM_BITS-1:0]  addr_dc3, end_dc3;
  logic [DATA_WIDTH-1:0] dat_hi, dat_lo;
  logic ovf, pend;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lsu_ecc_scrub_ctl_if bus ();

  lsu_ecc_scrub_ctl dut (
    .clk                      (clk),
    .rst_l                    (rst_l),
    .dec_tlu_core_ecc_disable (dis),
    .single_ecc_error_hi_dc3  (err_hi),
    .single_ecc_error_lo_dc3  (err_lo),
    .lsu_double_ecc_error_dc3 (dbl),
    .lsu_addr_dc3             (addr_dc3),
    .end_addr_dc3             (end_dc3),
    .sec_data_hi_dc3          (dat_hi),
    .sec_data_lo_dc3          (dat_lo),
    .lsu_commit_dc4           (commit),
    .bus                      (bus),
    .scrub_overflow           (ovf),
    .scrub_pending            (pend)
  );

  // reference Hamming(38,32) built from bit positions, plus overall parity
  function automatic logic [6:0] ref_ecc(input logic [31:0] d);
    logic [6:0] e;
    int k;
    e = '0;
    k = 0;
    for (int p = 1; k < 32; p++) begin
      if ((p & (p - 1)) != 0) begin
        for (int b = 0; b < 6; b++)
          if (((p >> b) & 1) != 0) e[b] = e[b] ^ d[k];
        k++;
      end
    end
    e[6] = ^{d, e[5:0]};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic dc3(input logic lo, input logic hi,
                     input logic [15:0] a, input logic [15:0] e,
                     input logic [31:0] dl, input logic [31:0] dh);
    err_lo = lo; err_hi = hi;
    addr_dc3 = a; end_dc3 = e;
    dat_lo = dl; dat_hi = dh;
  endtask

  task automatic dc3_idle();
    dc3(1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 32'h0);
  endtask

  initial begin
    dis = 1'b0; dbl = 1'b0; commit = 1'b1;
    dc3_idle();
    bus.stbuf_reqvld_any = 1'b0;
    bus.stbuf_addr_any = 16'h0;
    #12;
    chk("rst_wren", bus.scrub_wren, 0);
    chk("rst_grant", bus.stbuf_grant_any, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_addr", bus.scrub_wr_addr, 0);
    chk("rst_data", bus.scrub_wr_data, 0);
    chk("rst_ecc", bus.scrub_wr_ecc, 0);
    rst_l = 1'b1;

    // lo single error, idle stbuf: write at N+2
    nxt();
    dc3(1'b1, 1'b0, 16'h0104, 16'h0108, 32'hDEADBEEF, 32'h0);
    #1 chk("t1_n_pend", pend, 0);
    nxt(); dc3_idle();
    #1 chk("t1_n1_wren", bus.scrub_wren, 0);
    nxt();
    #1 chk("t1_n2_wren", bus.scrub_wren, 1);
    chk("t1_addr", bus.scrub_wr_addr, 16'h0104);
    chk("t1_data", bus.scrub_wr_data, 32'hDEADBEEF);
    chk("t1_ecc", bus.scrub_wr_ecc, ref_ecc(32'hDEADBEEF));
    chk("t1_pend", pend, 1);
    nxt();
    #1 chk("t1_pend_clr", pend, 0);
    chk("t1_wren_clr", bus.scrub_wren, 0);

    // dual error without commit: nothing queued
    nxt();
    dc3(1'b1, 1'b1, 16'h0FFC, 16'h1000, 32'h1234, 32'h5678);
    nxt(); dc3_idle(); commit = 1'b0;
    #1 chk("t2_ovf", ovf, 0);
    nxt(); commit = 1'b1;
    #1 chk("t2_wren", bus.scrub_wren, 0);
    chk("t2_pend", pend, 0);
    nxt();
    #1 chk("t2_wren2", bus.scrub_wren, 0);

    // fill queue under stbuf pressure, then overflow hi
    bus.stbuf_reqvld_any = 1'b1;
    bus.stbuf_addr_any = 16'h3000;
    nxt();
    dc3(1'b1, 1'b1, 16'h0010, 16'h0014, 32'h11111111, 32'h22222222);
    #1 chk("t3_a_grant", bus.stbuf_grant_any, 1);
    nxt();
    dc3(1'b1, 1'b1, 16'h0020, 16'h0024, 32'h33333333, 32'h44444444);
    #1 chk("t3_a1_ovf", ovf, 0);
    chk("t3_a1_grant", bus.stbuf_grant_any, 1);
    nxt(); dc3_idle();
    #1 chk("t3_full_wren", bus.scrub_wren, 1);
    chk("t3_full_addr", bus.scrub_wr_addr, 16'h0010);
    chk("t3_full_grant", bus.stbuf_grant_any, 0);
    chk("t3_ovf_pulse", ovf, 1);
    nxt();
    #1 chk("t3_wren2", bus.scrub_wren, 1);
    chk("t3_addr2", bus.scrub_wr_addr, 16'h0014);
    chk("t3_ovf_drop", ovf, 0);

    // one entry left: seven stbuf wins, then scrub
    for (int i = 0; i < 7; i++) begin
      nxt();
      #1 chk($sformatf("t4_starve%0d", i),
             {bus.stbuf_grant_any, bus.scrub_wren}, 2'b10);
    end
    nxt();
    #1 chk("t4_wren8", bus.scrub_wren, 1);
    chk("t4_addr8", bus.scrub_wr_addr, 16'h0020);
    chk("t4_data8", bus.scrub_wr_data, 32'h33333333);
    chk("t4_grant8", bus.stbuf_grant_any, 0);
    nxt();
    #1 chk("t4_pend", pend, 0);
    chk("t4_starve0", dut.r_starve_cnt, 0);

    // staged entry hit by same-cycle stbuf grant: silent drop
    bus.stbuf_addr_any = 16'h0302;
    nxt();
    dc3(1'b1, 1'b0, 16'h0300, 16'h0304, 32'hCAFE0001, 32'h0);
    nxt(); dc3_idle();
    #1 chk("t5_ovf", ovf, 0);
    chk("t5_grant", bus.stbuf_grant_any, 1);
    nxt(); bus.stbuf_reqvld_any = 1'b0;
    #1 chk("t5_pend", pend, 0);
    chk("t5_wren", bus.scrub_wren, 0);

    // queued entry invalidated by stbuf write to same word
    bus.stbuf_reqvld_any = 1'b1;
    bus.stbuf_addr_any = 16'h3000;
    nxt();
    dc3(1'b1, 1'b0, 16'h0200, 16'h0204, 32'hBEEF0200, 32'h0);
    nxt(); dc3_idle();
    #1 chk("t6_grant0", bus.stbuf_grant_any, 1);
    nxt(); bus.stbuf_addr_any = 16'h0202;
    #1 chk("t6_pend", pend, 1);
    chk("t6_grant", bus.stbuf_grant_any, 1);
    chk("t6_wren", bus.scrub_wren, 0);
    nxt(); bus.stbuf_reqvld_any = 1'b0;
    #1 chk("t6_skip_wren", bus.scrub_wren, 0);
    chk("t6_skip_pend", pend, 1);
    nxt();
    #1 chk("t6_pend_clr", pend, 0);
    chk("t6_wren_clr", bus.scrub_wren, 0);

    // ecc disable flushes two pending entries
    bus.stbuf_reqvld_any = 1'b1;
    bus.stbuf_addr_any = 16'h3000;
    nxt();
    dc3(1'b1, 1'b1, 16'h0040, 16'h0044, 32'hA0A0A0A0, 32'hB0B0B0B0);
    nxt(); dc3_idle();
    nxt(); dis = 1'b1;
    dc3(1'b1, 1'b0, 16'h0050, 16'h0054, 32'h0, 32'h0);
    #1 chk("t7_dis_wren", bus.scrub_wren, 0);
    chk("t7_dis_grant", bus.stbuf_grant_any, 1);
    chk("t7_dis_pend", pend, 1);
    nxt(); dis = 1'b0; dc3_idle();
    bus.stbuf_reqvld_any = 1'b0;
    #1 chk("t7_flush_pend", pend, 0);
    chk("t7_flush_wren", bus.scrub_wren, 0);
    nxt();
    #1 chk("t7_nocap_pend", pend, 0);

    // asynchronous reset with an entry about to write
    bus.stbuf_reqvld_any = 1'b1;
    nxt();
    dc3(1'b1, 1'b0, 16'h0080, 16'h0084, 32'h55AA55AA, 32'h0);
    nxt(); dc3_idle();
    nxt(); bus.stbuf_reqvld_any = 1'b0;
    #1 chk("t8_pre_wren", bus.scrub_wren, 1);
    chk("t8_pre_addr", bus.scrub_wr_addr, 16'h0080);
    #1 rst_l = 1'b0;
    #1 chk("t8_wren", bus.scrub_wren, 0);
    chk("t8_pend", pend, 0);
    chk("t8_grant", bus.stbuf_grant_any, 0);
    chk("t8_addr", bus.scrub_wr_addr, 0);
    chk("t8_data", bus.scrub_wr_data, 0);
    chk("t8_ecc", bus.scrub_wr_ecc, 0);
    chk("t8_ovf", ovf, 0);
    #10 rst_l = 1'b1;
    nxt();
    #1 chk("t8_post_pend", pend, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_ecc_scrub_ctl.md
Name: lsu_ecc_scrub_ctl

Overview:
- Schedules write-back of single-bit-corrected DCCM words found by the dc3 ECC decode on loads and stores, so latent errors are scrubbed from the array.
- Captures corrected hi/lo bank data in dc3 and qualifies it at dc4 commit.
- Queues committed corrections and arbitrates the shared DCCM write port against the store-buffer drain.
- Sits in the LSU beside the ECC decode/encode datapath and the store buffer.

Parameters:
DCCM_BITS, 16, DCCM byte-address width (from RV_DCCM_BITS)
DATA_WIDTH, 32, DCCM bank data width
ECC_WIDTH, 7, ECC bits per bank word
DEPTH, 2, scrub queue entries (power of 2, >=2)
STARVE_MAX, 7, consecutive stbuf wins tolerated while queue non-empty

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
dec_tlu_core_ecc_disable  in  1  ECC disabled; flush queue, block captures
single_ecc_error_hi_dc3  in  1  corrected error, hi bank, dc3
single_ecc_error_lo_dc3  in  1  corrected error, lo bank, dc3
lsu_double_ecc_error_dc3  in  1  uncorrectable error in access; suppresses capture
lsu_addr_dc3  in  DCCM_BITS  start address dc3
end_addr_dc3  in  DCCM_BITS  end address dc3 (hi bank word)
sec_data_hi_dc3  in  DATA_WIDTH  corrected hi word
sec_data_lo_dc3  in  DATA_WIDTH  corrected lo word
lsu_commit_dc4  in  1  dc4 instruction commits (not flushed)
stbuf_reqvld_any  in  1  store buffer requests DCCM write
stbuf_addr_any  in  DCCM_BITS  store buffer drain address
stbuf_grant_any  out  1  store buffer write granted this cycle
scrub_wren  out  1  scrub write to DCCM this cycle
scrub_wr_addr  out  DCCM_BITS  scrub address, [1:0]=0
scrub_wr_data  out  DATA_WIDTH  scrub data
scrub_wr_ecc  out  ECC_WIDTH  ECC of scrub_wr_data
scrub_overflow  out  1  one-cycle pulse, correction dropped
scrub_pending  out  1  queue non-empty

Behaviour:
- Reset: all queue valids, pointers, dc4 staging, and starve_cnt are 0. All outputs are 0.
- dc3 capture, into flops clocked every cycle:
  - stg_vld_lo = single_ecc_error_lo_dc3 & ~lsu_double_ecc_error_dc3 & ~ecc_disable
  - stg_vld_hi = same condition using the hi error.
  - Address is {lsu_addr_dc3[DCCM_BITS-1:2],2'b0} for lo and {end_addr_dc3[DCCM_BITS-1:2],2'b0} for hi; data is the matching sec_data.
- dc4 enqueue: a staged entry enqueues only if lsu_commit_dc4 & ~ecc_disable. Otherwise it is discarded silently.
  - Lo enqueues before hi.
  - If only one slot is free, lo enqueues, hi is dropped, and scrub_overflow=1.
  - If the queue is full, both are dropped and scrub_overflow=1.
  - A staged entry whose word address equals a stbuf write granted the same cycle is dropped without overflow.
- Queue: circular FIFO with wr/rd pointers plus a count. Pointers wrap modulo DEPTH. A dequeue and an enqueue in the same cycle are legal when full (dequeue frees the slot first).
- Arbitration, evaluated combinationally each cycle from registered state:
  - scrub_sel = pending & (~stbuf_reqvld_any | full | starve_cnt==STARVE_MAX)
  - scrub_wren = scrub_sel; stbuf_grant_any = stbuf_reqvld_any & ~scrub_sel
  - scrub_wr_addr/data come from the queue head. scrub_wr_ecc = rvecc_encode(head data).
  - On scrub_wren: dequeue and clear starve_cnt.
  - On a stbuf grant while pending: starve_cnt increments, saturating at STARVE_MAX.
  - When not pending: starve_cnt=0.
- Coherence: on stbuf_grant_any, every valid queue entry whose word address equals stbuf_addr_any[DCCM_BITS-1:2] is invalidated, because the stbuf word is a full merged word that supersedes the correction.
  - Invalidated entries are skipped at dequeue: the head advances without a write, one entry per cycle.
  - scrub_wren is never asserted for an invalid head.
- ecc_disable high: queue flushes next cycle (valids, pointers, count=0), no captures, scrub_wren=0, and the stbuf is granted whenever it requests.
- Latency: error in dc3 at cycle N -> staged N+1 (dc4) -> earliest scrub_wren at N+2 with an idle stbuf.
- Reset mid-operation: queue contents are lost. No partial write is issued, since the write is single-cycle.

Decomposition:
- Shared package swerv_types gains scrub_entry_t {valid, addr[DCCM_BITS-1:2], data[DATA_WIDTH-1:0]}.
- DEPTH and STARVE_MAX are localparams.
- Sub-module: lsu_ecc_scrub_fifo (entries, pointers, count, address-match invalidate).
- ECC generation reuses rvecc_encode.

Test Plan:
- Lo single error at addr 0x0104, data 0xDEADBEEF, commit, stbuf idle -> at N+2, scrub_wren=1, addr=0x0104, data=0xDEADBEEF, ecc=encode(0xDEADBEEF); pending drops the next cycle.
- Dual-bank error at lo=0x0FFC/hi=0x1000, lsu_commit_dc4=0 -> no enqueue, scrub_wren never asserted, no overflow.
- Queue full (2 entries), stbuf_reqvld_any held high, new hi+lo error committed -> scrub wins (full), one entry dequeued; lo enqueues, hi drops, scrub_overflow pulses 1 cycle.
- One entry pending, stbuf requesting continuously -> stbuf granted 7 consecutive cycles, scrub_wren on the 8th, starve_cnt returns to 0.
- Entry pending at 0x0200, stbuf granted to 0x0202 -> entry invalidated; scrub_wren never asserted for it; pending clears after the skip.
- Two entries pending, dec_tlu_core_ecc_disable=1 -> next cycle pending=0, scrub_wren=0. Separately, assert rst_l low mid-queue -> all outputs 0 immediately.
